// File: rtl/sdp_cmux_pkg.sv
// rtl/sdp_cmux_pkg.sv - shared constants and types for the SDP input selector
// Purpose: default beat width, payload bit positions and the FSM state type.
// Ports: none (package).
package sdp_cmux_pkg;

  localparam int DW_DEF    = 128;        // data bits per beat
  localparam int BATCH_END = DW_DEF;     // source pd bit: batch end
  localparam int LAYER_END = DW_DEF + 1; // source pd bit: layer end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } cmux_state_e;

endpackage

// File: rtl/sdp_core_cmux_if.sv
// rtl/sdp_core_cmux_if.sv - valid/ready/pd stream interface
// Purpose: one beat stream between SDP blocks.
// Ports (signals): valid (producer), ready (consumer), pd[W-1:0] (producer).
// Modports: master = producer side, slave = consumer side.
interface sdp_core_cmux_if
  import sdp_cmux_pkg::*;
#(
  parameter int W = DW_DEF + 2
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] pd;

  modport master (output valid, output pd, input ready);
  modport slave  (input valid, input pd, output ready);
endinterface

// File: rtl/sdp_cmux_skid.sv
// rtl/sdp_cmux_skid.sv - 2-entry registered skid buffer
// Purpose: registers a valid/ready stream at full throughput with no
//          combinational path from out_ready to in_ready.
// Ports: clk, rst (sync active-high); in_valid/in_ready/in_pd (upstream);
//        out_valid/out_ready/out_pd (downstream); W = payload width.
module sdp_cmux_skid #(
  parameter int W = 129
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_pd,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_pd
);
  // head_q always feeds the output; tail_q holds the second beat when full.
  logic [1:0]   cnt_q, cnt_d;
  logic         rdy_q, rdy_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         push, pop;

  always_comb begin
    push   = in_valid & rdy_q;
    pop    = (cnt_q != 2'd0) & out_ready;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    unique case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = in_pd;
        else               tail_d = in_pd;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        if (cnt_q == 2'd2) head_d = tail_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        // Count is unchanged; the queue shifts by one.
        if (cnt_q == 2'd2) begin
          head_d = tail_q;
          tail_d = in_pd;
        end else begin
          head_d = in_pd;
        end
      end
      default: ;
    endcase
    // Ready is precomputed from the next count so it can be a flop.
    rdy_d = (cnt_d != 2'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      rdy_q  <= 1'b0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      rdy_q  <= rdy_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = (cnt_q != 2'd0);
  assign out_pd    = head_q;

endmodule

// File: rtl/sdp_core_cmux.sv
// rtl/sdp_core_cmux.sv - SDP input selector (CACC flying vs MRDMA stream)
// Purpose: per layer, forwards one source stream to the SDP datapath via a
//          2-entry skid, tracks layer end, pulses done, counts output beats.
// Ports: nvdla_core_clk, nvdla_core_rst (sync active-high); op_load (layer
//        start pulse); reg2dp_flying_mode (1=CACC, 0=MRDMA); cacc2sdp and
//        sdp_mrdma2cmux (slave streams, pd = {layer_end, batch_end, data});
//        sdp_cmux2dp (master stream, pd = {layer_end, data}); cmux_done
//        (layer delivered pulse); dp2reg_cmux_beat_num (saturating count).
module sdp_core_cmux
  import sdp_cmux_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rst,
  input  logic                   op_load,
  input  logic                   reg2dp_flying_mode,
  sdp_core_cmux_if.slave         cacc2sdp,
  sdp_core_cmux_if.slave         sdp_mrdma2cmux,
  sdp_core_cmux_if.master        sdp_cmux2dp,
  output logic                   cmux_done,
  output logic [31:0]            dp2reg_cmux_beat_num
);
  localparam int LE_IDX = DW + 1;

  cmux_state_e state_q, state_d;
  logic        mode_q, mode_d;
  logic [31:0] beat_cnt_q, beat_cnt_d;
  logic        done_q, done_d;

  logic          run, sel_valid, acc, out_xfer;
  logic [DW+1:0] sel_pd;
  logic          skid_in_valid, skid_in_ready, skid_out_valid;
  logic [DW:0]   skid_in_pd, skid_out_pd;

  // Source mux: the unselected source never sees ready, so its beats stay put.
  always_comb begin
    run                  = (state_q == RUN);
    sel_valid            = mode_q ? cacc2sdp.valid : sdp_mrdma2cmux.valid;
    sel_pd               = mode_q ? cacc2sdp.pd    : sdp_mrdma2cmux.pd;
    skid_in_valid        = run & sel_valid;
    skid_in_pd           = {sel_pd[LE_IDX], sel_pd[DW-1:0]};
    cacc2sdp.ready       = run &  mode_q & skid_in_ready;
    sdp_mrdma2cmux.ready = run & ~mode_q & skid_in_ready;
    acc                  = skid_in_valid & skid_in_ready;
    out_xfer             = skid_out_valid & sdp_cmux2dp.ready;
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    beat_cnt_d = beat_cnt_q;
    done_d     = 1'b0;
    if (out_xfer && (beat_cnt_q != 32'hFFFF_FFFF)) beat_cnt_d = beat_cnt_q + 32'd1;
    unique case (state_q)
      IDLE: begin
        if (op_load) begin
          mode_d     = reg2dp_flying_mode;
          beat_cnt_d = 32'd0;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (acc && sel_pd[LE_IDX]) state_d = DRAIN;
      end
      DRAIN: begin
        // Only the final accepted beat carries layer_end, so seeing it
        // leave means the skid is now empty.
        if (out_xfer && skid_out_pd[DW]) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      beat_cnt_q <= 32'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      beat_cnt_q <= beat_cnt_d;
      done_q     <= done_d;
    end
  end

  sdp_cmux_skid #(.W(DW + 1)) u_skid (
    .clk       (nvdla_core_clk),
    .rst       (nvdla_core_rst),
    .in_valid  (skid_in_valid),
    .in_ready  (skid_in_ready),
    .in_pd     (skid_in_pd),
    .out_valid (skid_out_valid),
    .out_ready (sdp_cmux2dp.ready),
    .out_pd    (skid_out_pd)
  );

  assign sdp_cmux2dp.valid    = skid_out_valid;
  assign sdp_cmux2dp.pd       = skid_out_pd;
  assign cmux_done            = done_q;
  assign dp2reg_cmux_beat_num = beat_cnt_q;

endmodule
